// File: rtl/busca_pkg.sv
// Shared types and defaults for the nRisc instruction-fetch sequencer.
package busca_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int CONT_W = 16;
    localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

endpackage

// File: rtl/controlador_busca_if.sv
// Fetch-side bus: instruction-memory address/data, pipeline control and the decode-facing outputs.
interface controlador_busca_if #(
    parameter int ADDR_W = busca_pkg::ADDR_W_DEF,
    parameter int INSTR_W = busca_pkg::INSTR_W_DEF
);
    logic [ADDR_W-1:0]          Endereco;
    logic [INSTR_W-1:0]         Instrucao;
    logic                       Stall;
    logic                       Desvio;
    logic [ADDR_W-1:0]          AlvoDesvio;
    logic [INSTR_W-1:0]         InstrSaida;
    logic [ADDR_W-1:0]          PcSaida;
    logic                       InstrValida;
    logic                       Parado;
    logic [busca_pkg::CONT_W-1:0] ContadorInstr;

    modport master (
        output Endereco, InstrSaida, PcSaida, InstrValida, Parado, ContadorInstr,
        input  Instrucao, Stall, Desvio, AlvoDesvio
    );

    modport slave (
        input  Endereco, InstrSaida, PcSaida, InstrValida, Parado, ContadorInstr,
        output Instrucao, Stall, Desvio, AlvoDesvio
    );
endinterface

// File: rtl/contador_instrucoes.sv
// Saturating event counter with enable and synchronous clear.
module contador_instrucoes
    import busca_pkg::*;
#(
    parameter int W = CONT_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         en,
    output logic [W-1:0] valor
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valor <= '0;
        end else if (en && (valor != '1)) begin
            valor <= valor + W'(1);
        end
    end

endmodule

// File: rtl/controlador_busca.sv
// Instruction-fetch sequencer: owns the PC, captures memory bytes, handles stall/branch/halt.
// Optional issued-instruction counter enabled by defining BUSCA_CONTADOR_EN.
//
// state  | meaning
// INICIO | one cycle after reset so the memory output catches up with the PC
// BUSCA  | fetching, one capture per unstalled cycle
// PARADO | halt opcode executed; only Reset leaves
module controlador_busca
    import busca_pkg::*;
#(
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 INSTR_W     = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(HALT_OPCODE_DEF)
) (
    input logic Clock,
    input logic Reset,
    controlador_busca_if.master bus
);

    estado_t             estado, estado_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [INSTR_W-1:0]  instr_q, instr_next;
    logic [ADDR_W-1:0]   pcs_q, pcs_next;
    logic                valida_q, valida_next;
    logic                parado_q, parado_next;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= INICIO;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pcs_q    <= '0;
            valida_q <= 1'b0;
            parado_q <= 1'b0;
        end else begin
            estado   <= estado_next;
            pc       <= pc_next;
            instr_q  <= instr_next;
            pcs_q    <= pcs_next;
            valida_q <= valida_next;
            parado_q <= parado_next;
        end
    end

    always_comb begin
        estado_next = estado;
        pc_next     = pc;
        instr_next  = instr_q;
        pcs_next    = pcs_q;
        valida_next = valida_q;
        parado_next = parado_q;
        case (estado)
            INICIO: estado_next = BUSCA;
            BUSCA: begin
                // Branch wins over stall and over a pending halt; the byte in flight is squashed.
                if (bus.Desvio) begin
                    pc_next     = bus.AlvoDesvio;
                    valida_next = 1'b0;
                end else if (bus.Stall) begin
                    estado_next = BUSCA;
                end else if (valida_q && (instr_q == HALT_OPCODE)) begin
                    estado_next = PARADO;
                    parado_next = 1'b1;
                    valida_next = 1'b0;
                end else begin
                    instr_next  = bus.Instrucao;
                    pcs_next    = pc;
                    pc_next     = pc + ADDR_W'(1);
                    valida_next = 1'b1;
                end
            end
            PARADO: estado_next = PARADO;
            default: estado_next = INICIO;
        endcase
    end

    assign bus.Endereco    = pc;
    assign bus.InstrSaida  = instr_q;
    assign bus.PcSaida     = pcs_q;
    assign bus.InstrValida = valida_q;
    assign bus.Parado      = parado_q;

`ifdef BUSCA_CONTADOR_EN
    logic captura;

    assign captura = (estado == BUSCA) && !bus.Desvio && !bus.Stall
                     && !(valida_q && (instr_q == HALT_OPCODE));

    contador_instrucoes #(.W(CONT_W)) u_contador (
        .Clock (Clock),
        .Reset (Reset),
        .en    (captura),
        .valor (bus.ContadorInstr)
    );
`else
    assign bus.ContadorInstr = '0;
`endif

endmodule

// File: tb/tb_controlador_busca.sv
// Scoreboard bench for controlador_busca: per-cycle expected outputs queued by the stimulus, checked by a monitor.
module tb_controlador_busca;
    import busca_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controlador_busca_if bus ();

    controlador_busca dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [7:0] mem [256];

    always @(negedge clk) bus.Instrucao <= mem[bus.Endereco];

    typedef struct {
        logic        v;
        logic [7:0]  pcs;
        logic [7:0]  ins;
        logic [7:0]  ender;
        logic        par;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    // reference model: abstract fetch stream
    bit         m_started, m_halted, m_v;
    logic [7:0] m_pc, m_ins, m_pcs;
    int         m_cnt;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, want, $time);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit dv, input logic [7:0] alvo);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r;
        bus.Stall = st;
        bus.Desvio = dv;
        bus.AlvoDesvio = alvo;
        if (r) begin
            m_pc = 8'h00; m_ins = 8'h00; m_pcs = 8'h00;
            m_v = 1'b0; m_cnt = 0; m_started = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_v = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (dv) begin
            m_pc = alvo;
            m_v = 1'b0;
        end else if (st) begin
            m_v = m_v;
        end else if (m_v && m_ins == 8'hFF) begin
            m_halted = 1'b1;
            m_v = 1'b0;
        end else begin
            m_ins = mem[m_pc];
            m_pcs = m_pc;
            m_pc = 8'((int'(m_pc) + 1) % 256);
            m_v = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        e.v = m_v;
        e.pcs = m_pcs;
        e.ins = m_ins;
        e.ender = m_pc;
        e.par = m_halted;
`ifdef BUSCA_CONTADOR_EN
        e.cnt = 16'(m_cnt);
`else
        e.cnt = 16'h0000;
`endif
        q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("InstrValida", 32'(bus.InstrValida), 32'(e.v));
            check("PcSaida", 32'(bus.PcSaida), 32'(e.pcs));
            check("InstrSaida", 32'(bus.InstrSaida), 32'(e.ins));
            check("Endereco", 32'(bus.Endereco), 32'(e.ender));
            check("Parado", 32'(bus.Parado), 32'(e.par));
            check("ContadorInstr", 32'(bus.ContadorInstr), 32'(e.cnt));
        end
    end

    initial begin
        bus.Stall = 1'b0;
        bus.Desvio = 1'b0;
        bus.AlvoDesvio = 8'h00;
        bus.Instrucao = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        mem[8'h23] = 8'hFF;
        mem[8'h90] = 8'hFF;
        mem[8'hC7] = 8'hFF;

        // reset, then sequential fetch from 0
        repeat (2) step(1, 0, 0, 8'h00);
        repeat (6) step(0, 0, 0, 8'h00);
        // stall holds everything
        repeat (3) step(0, 1, 0, 8'h00);
        repeat (2) step(0, 0, 0, 8'h00);
        // branch with simultaneous stall
        step(0, 1, 1, 8'h40);
        repeat (3) step(0, 0, 0, 8'h00);
        // wrap-around
        step(0, 0, 1, 8'hFE);
        repeat (5) step(0, 0, 0, 8'h00);
        // halt at 0x23, then branch/stall ignored
        step(0, 0, 1, 8'h20);
        repeat (6) step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h55);
        step(0, 0, 1, 8'h10);
        // reset out of halt, then reset during stall
        step(1, 0, 0, 8'h00);
        repeat (4) step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        repeat (5) step(0, 0, 0, 8'h00);

        for (int n = 0; n < 500; n++) begin
            bit r, st, dv;
            r  = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 3) == 0);
            st = $urandom_range(0, 99) < 25;
            dv = $urandom_range(0, 99) < 10;
            step(r, st, dv, 8'($urandom_range(0, 255)));
        end

        repeat (3) @(posedge clk);
        #5;
        check("fila_vazia", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
